// File: rtl/wb_pkg.sv
// Shared types for the writeback-select stage: load sizes, FSM states,
// default source indices and the captured load-control bundle.
package wb_pkg;

  typedef enum logic [1:0] {
    LS_BYTE = 2'd0,
    LS_HALF = 2'd1,
    LS_WORD = 2'd2
  } load_size_t;

  typedef enum logic {
    WB_IDLE     = 1'b0,
    WB_WAIT_MEM = 1'b1
  } wb_state_t;

  localparam int SRC_ALU  = 0;
  localparam int SRC_MEM  = 1;
  localparam int SRC_LINK = 2;
  localparam int SRC_IMM  = 3;

  // Load shaping controls, held while waiting on memory
  typedef struct packed {
    logic [1:0] size;
    logic       uns;
    logic [1:0] off;
  } load_ctl_t;

endpackage

// File: rtl/load_align_extend.sv
// Picks the addressed byte/half/word out of a raw memory read word and
// zero- or sign-extends it to DATA_W. Size code 3 is treated as a word.
module load_align_extend
  import wb_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] word,
  input  logic [1:0]        size,
  input  logic              uns,
  input  logic [1:0]        offset,
  output logic [DATA_W-1:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // half selection uses only offset[1]; offset[0] is ignored for halves
  assign byte_sel = word[{offset, 3'b000} +: 8];
  assign half_sel = word[{offset[1], 4'b0000} +: 16];

  // extend the selected field according to size and signedness
  always_comb begin
    data = word;
    if (size == LS_BYTE)
      data = uns ? {{(DATA_W-8){1'b0}}, byte_sel}
                 : {{(DATA_W-8){byte_sel[7]}}, byte_sel};
    else if (size == LS_HALF)
      data = uns ? {{(DATA_W-16){1'b0}}, half_sel}
                 : {{(DATA_W-16){half_sel[15]}}, half_sel};
  end

endmodule

// File: rtl/writeback_select_stage.sv
// Registered writeback select: muxes one of NUM_SRC results, shapes load
// data from the memory source, waits on slow memory, and emits one
// registered register-file write per completed instruction.
module writeback_select_stage
  import wb_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int NUM_SRC    = 4,
  parameter int MEM_IDX    = SRC_MEM,
  parameter int REG_ADDR_W = 5,
  parameter int SEL_W      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                      Clk,
  input  logic                      Rst,
  input  logic                      In_Valid,
  output logic                      In_Ready,
  input  logic                      Stall,
  input  logic                      Flush,
  input  logic [SEL_W-1:0]          WB_Sel,
  input  logic [NUM_SRC*DATA_W-1:0] Src_Data,
  input  logic                      Mem_Data_Valid,
  input  logic [1:0]                Load_Size,
  input  logic                      Load_Unsigned,
  input  logic [1:0]                Byte_Offset,
  input  logic [REG_ADDR_W-1:0]     Dest_Reg,
  input  logic                      Reg_Write,
  output logic                      Out_Valid,
  output logic                      Out_Reg_Write,
  output logic [REG_ADDR_W-1:0]     Out_Dest_Reg,
  output logic [DATA_W-1:0]         Write_Data_Output,
  output logic                      Busy
);

  wb_state_t                       state;
  logic [NUM_SRC-1:0][DATA_W-1:0]  src;
  logic [DATA_W-1:0]               sel_data;
  logic [DATA_W-1:0]               aligned;
  logic                            accept;
  logic                            sel_mem;
  load_ctl_t                       live_ctl, pend_ctl, align_ctl;
  logic [REG_ADDR_W-1:0]           pend_dest;
  logic                            pend_rw;

  assign src      = Src_Data;
  assign In_Ready = (state == WB_IDLE) && !Stall;
  assign Busy     = (state == WB_WAIT_MEM);
  assign accept   = In_Valid && In_Ready;
  assign sel_mem  = (int'(WB_Sel) == MEM_IDX);

  assign live_ctl  = '{size: Load_Size, uns: Load_Unsigned, off: Byte_Offset};
  // while waiting, the memory word is shaped by the controls captured at accept
  assign align_ctl = (state == WB_WAIT_MEM) ? pend_ctl : live_ctl;

  load_align_extend #(.DATA_W(DATA_W)) u_align (
    .word   (src[MEM_IDX]),
    .size   (align_ctl.size),
    .uns    (align_ctl.uns),
    .offset (align_ctl.off),
    .data   (aligned)
  );

  // source mux; out-of-range selects write zero
  always_comb begin
    sel_data = '0;
    if (int'(WB_Sel) < NUM_SRC)
      sel_data = sel_mem ? aligned : src[WB_Sel];
  end

  // FSM and output register; Flush outranks everything except reset
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state             <= WB_IDLE;
      Out_Valid         <= 1'b0;
      Out_Reg_Write     <= 1'b0;
      Out_Dest_Reg      <= '0;
      Write_Data_Output <= '0;
      pend_dest         <= '0;
      pend_rw           <= 1'b0;
      pend_ctl          <= '0;
    end else begin
      Out_Valid     <= 1'b0;
      Out_Reg_Write <= 1'b0;
      case (state)
        WB_IDLE: begin
          if (!Flush && accept) begin
            if (sel_mem && !Mem_Data_Valid) begin
              state     <= WB_WAIT_MEM;
              pend_dest <= Dest_Reg;
              pend_rw   <= Reg_Write;
              pend_ctl  <= live_ctl;
            end else begin
              Out_Valid         <= 1'b1;
              Out_Reg_Write     <= Reg_Write;
              Out_Dest_Reg      <= Dest_Reg;
              Write_Data_Output <= sel_data;
            end
          end
        end
        WB_WAIT_MEM: begin
          if (Flush) begin
            state <= WB_IDLE;
          end else if (Mem_Data_Valid) begin
            state             <= WB_IDLE;
            Out_Valid         <= 1'b1;
            Out_Reg_Write     <= pend_rw;
            Out_Dest_Reg      <= pend_dest;
            Write_Data_Output <= aligned;
          end
        end
        default: state <= WB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_writeback_select_stage.sv
// Directed bench: expected writes go into a scoreboard queue when driven and
// are popped by a monitor whenever the stage pulses Out_Valid.
module tb_writeback_select_stage;

  logic             Clk = 1'b0;
  logic             Rst;
  logic             In_Valid, In_Ready, Stall, Flush;
  logic [1:0]       WB_Sel;
  logic [3:0][31:0] src;
  logic [127:0]     Src_Data;
  logic             Mem_Data_Valid;
  logic [1:0]       Load_Size;
  logic             Load_Unsigned;
  logic [1:0]       Byte_Offset;
  logic [4:0]       Dest_Reg;
  logic             Reg_Write;
  logic             Out_Valid, Out_Reg_Write, Busy;
  logic [4:0]       Out_Dest_Reg;
  logic [31:0]      Write_Data_Output;

  typedef struct {
    logic [4:0]  dest;
    logic        rw;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  assign Src_Data = src;
  always #5 Clk = ~Clk;

  writeback_select_stage dut (
    .Clk(Clk), .Rst(Rst), .In_Valid(In_Valid), .In_Ready(In_Ready),
    .Stall(Stall), .Flush(Flush), .WB_Sel(WB_Sel), .Src_Data(Src_Data),
    .Mem_Data_Valid(Mem_Data_Valid), .Load_Size(Load_Size),
    .Load_Unsigned(Load_Unsigned), .Byte_Offset(Byte_Offset),
    .Dest_Reg(Dest_Reg), .Reg_Write(Reg_Write), .Out_Valid(Out_Valid),
    .Out_Reg_Write(Out_Reg_Write), .Out_Dest_Reg(Out_Dest_Reg),
    .Write_Data_Output(Write_Data_Output), .Busy(Busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] sel, input logic [31:0] d, input logic mdv,
                       input logic [1:0] sz, input logic uns, input logic [1:0] off,
                       input logic [4:0] dst, input logic rw);
    In_Valid = 1'b1; WB_Sel = sel; src[sel] = d; Mem_Data_Valid = mdv;
    Load_Size = sz; Load_Unsigned = uns; Byte_Offset = off;
    Dest_Reg = dst; Reg_Write = rw;
  endtask

  task automatic push(input logic [4:0] dst, input logic rw, input logic [31:0] d);
    exp_t e;
    e.dest = dst; e.rw = rw; e.data = d;
    sb.push_back(e);
  endtask

  task automatic idle_in;
    In_Valid = 1'b0; Mem_Data_Valid = 1'b0; Flush = 1'b0; Stall = 1'b0;
  endtask

  // a one-cycle, single-shot load and check of its data on the next edge
  task automatic one_shot(input string tag, input logic [1:0] sel, input logic [31:0] d,
                          input logic mdv, input logic [1:0] sz, input logic uns,
                          input logic [1:0] off, input logic [4:0] dst, input logic rw,
                          input logic [31:0] exp_d);
    drive(sel, d, mdv, sz, uns, off, dst, rw);
    push(dst, rw, exp_d);
    tick;
    idle_in;
    chk({tag, "_valid"}, {63'd0, Out_Valid}, 64'd1);
    chk({tag, "_data"}, {32'd0, Write_Data_Output}, {32'd0, exp_d});
    chk({tag, "_rw"}, {63'd0, Out_Reg_Write}, {63'd0, rw});
  endtask

  // scoreboard monitor: every pulse must match the oldest expected write
  always @(negedge Clk) begin
    if (!Rst && Out_Valid) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_pulse", {63'd0, Out_Valid}, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_dest", {59'd0, Out_Dest_Reg}, {59'd0, e.dest});
        chk("sb_rw", {63'd0, Out_Reg_Write}, {63'd0, e.rw});
        chk("sb_data", {32'd0, Write_Data_Output}, {32'd0, e.data});
      end
    end
  end

  initial begin
    Rst = 1'b1; src = '0; WB_Sel = '0; Load_Size = '0; Load_Unsigned = 1'b0;
    Byte_Offset = '0; Dest_Reg = '0; Reg_Write = 1'b0;
    idle_in;
    tick; tick;
    chk("rst_valid", {63'd0, Out_Valid}, 64'd0);
    chk("rst_rw", {63'd0, Out_Reg_Write}, 64'd0);
    chk("rst_dest", {59'd0, Out_Dest_Reg}, 64'd0);
    chk("rst_data", {32'd0, Write_Data_Output}, 64'd0);
    chk("rst_busy", {63'd0, Busy}, 64'd0);
    Rst = 1'b0;
    tick;

    // ALU pass-through, latency 1, single-cycle pulse
    drive(2'd0, 32'h0000_0001, 1'b0, 2'd0, 1'b0, 2'd0, 5'd5, 1'b1);
    #1 chk("alu_ready", {63'd0, In_Ready}, 64'd1);
    push(5'd5, 1'b1, 32'h0000_0001);
    tick;
    idle_in;
    chk("alu_valid", {63'd0, Out_Valid}, 64'd1);
    chk("alu_data", {32'd0, Write_Data_Output}, 64'd1);
    chk("alu_dest", {59'd0, Out_Dest_Reg}, 64'd5);
    chk("alu_rw", {63'd0, Out_Reg_Write}, 64'd1);
    tick;
    chk("alu_pulse_end", {63'd0, Out_Valid}, 64'd0);
    chk("alu_data_hold", {32'd0, Write_Data_Output}, 64'd1);

    // load shaping with memory data ready on accept
    one_shot("sb_off3", 2'd1, 32'h80FF_7F00, 1'b1, 2'd0, 1'b0, 2'd3, 5'd6, 1'b1, 32'hFFFF_FF80);
    one_shot("ub_off1", 2'd1, 32'h80FF_7F00, 1'b1, 2'd0, 1'b1, 2'd1, 5'd7, 1'b1, 32'h0000_007F);
    one_shot("sh_off2", 2'd1, 32'h80FF_7F00, 1'b1, 2'd1, 1'b0, 2'd2, 5'd8, 1'b1, 32'hFFFF_80FF);
    one_shot("sh_off1", 2'd1, 32'h80FF_7F00, 1'b1, 2'd1, 1'b0, 2'd1, 5'd8, 1'b1, 32'h0000_7F00);
    one_shot("uh_off3", 2'd1, 32'h80FF_7F00, 1'b1, 2'd1, 1'b1, 2'd3, 5'd8, 1'b1, 32'h0000_80FF);
    one_shot("word_off1", 2'd1, 32'h80FF_7F00, 1'b1, 2'd2, 1'b0, 2'd1, 5'd9, 1'b1, 32'h80FF_7F00);
    one_shot("word_sz3", 2'd1, 32'hC0DE_0081, 1'b1, 2'd3, 1'b0, 2'd2, 5'd9, 1'b1, 32'hC0DE_0081);
    // non-MEM sources ignore load controls; Reg_Write=0 passes through
    one_shot("link_nowr", 2'd2, 32'h0040_0008, 1'b0, 2'd0, 1'b0, 2'd3, 5'd31, 1'b0, 32'h0040_0008);
    one_shot("imm_pass", 2'd3, 32'hFFFF_8000, 1'b0, 2'd1, 1'b1, 2'd0, 5'd4, 1'b1, 32'hFFFF_8000);

    // variable-latency memory: three empty cycles then data
    drive(2'd1, 32'hDEAD_BEEF, 1'b0, 2'd2, 1'b0, 2'd0, 5'd9, 1'b1);
    push(5'd9, 1'b1, 32'h1234_5678);
    tick;
    // change live controls and offer an ALU op: neither may be taken while waiting
    drive(2'd0, 32'h5555_5555, 1'b0, 2'd0, 1'b1, 2'd3, 5'd1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("wait_busy", {63'd0, Busy}, 64'd1);
      chk("wait_ready", {63'd0, In_Ready}, 64'd0);
      chk("wait_novalid", {63'd0, Out_Valid}, 64'd0);
      if (i < 2) tick;
    end
    src[1] = 32'h1234_5678; Mem_Data_Valid = 1'b1;
    tick;
    idle_in;
    chk("wait_valid", {63'd0, Out_Valid}, 64'd1);
    chk("wait_data", {32'd0, Write_Data_Output}, 64'h1234_5678);
    chk("wait_busy_clr", {63'd0, Busy}, 64'd0);
    tick;
    chk("wait_pulse_end", {63'd0, Out_Valid}, 64'd0);

    // Flush in WAIT_MEM coincident with Mem_Data_Valid: no write, back to IDLE
    drive(2'd1, 32'h0, 1'b0, 2'd2, 1'b0, 2'd0, 5'd10, 1'b1);
    tick;
    In_Valid = 1'b0;
    chk("fl_busy", {63'd0, Busy}, 64'd1);
    Flush = 1'b1; Mem_Data_Valid = 1'b1; src[1] = 32'hAAAA_0000;
    tick;
    idle_in;
    #1;
    chk("fl_novalid", {63'd0, Out_Valid}, 64'd0);
    chk("fl_idle", {63'd0, Busy}, 64'd0);
    chk("fl_ready", {63'd0, In_Ready}, 64'd1);
    chk("fl_hold_data", {32'd0, Write_Data_Output}, 64'h1234_5678);
    tick;

    // Flush in IDLE drops the incoming instruction
    drive(2'd0, 32'h0BAD_0BAD, 1'b0, 2'd0, 1'b0, 2'd0, 5'd11, 1'b1);
    Flush = 1'b1;
    tick;
    idle_in;
    chk("fl_idle_drop", {63'd0, Out_Valid}, 64'd0);

    // Stall blocks acceptance; release gives exactly one pulse
    drive(2'd0, 32'hAAAA_5555, 1'b0, 2'd0, 1'b0, 2'd0, 5'd3, 1'b1);
    Stall = 1'b1;
    #1 chk("st_ready", {63'd0, In_Ready}, 64'd0);
    tick;
    chk("st_novalid1", {63'd0, Out_Valid}, 64'd0);
    tick;
    chk("st_novalid2", {63'd0, Out_Valid}, 64'd0);
    Stall = 1'b0;
    push(5'd3, 1'b1, 32'hAAAA_5555);
    tick;
    idle_in;
    chk("st_valid", {63'd0, Out_Valid}, 64'd1);
    tick;
    chk("st_single", {63'd0, Out_Valid}, 64'd0);

    // Stall during WAIT_MEM does not block the completing pulse
    drive(2'd1, 32'h0, 1'b0, 2'd0, 1'b0, 2'd2, 5'd12, 1'b1);
    tick;
    In_Valid = 1'b0; Stall = 1'b1;
    src[1] = 32'h0085_0000; Mem_Data_Valid = 1'b1;
    push(5'd12, 1'b1, 32'hFFFF_FF85);
    tick;
    idle_in;
    chk("st_wait_valid", {63'd0, Out_Valid}, 64'd1);
    tick;

    // Mem_Data_Valid in IDLE without a MEM accept is ignored
    Mem_Data_Valid = 1'b1;
    tick;
    idle_in;
    chk("mdv_idle_ignored", {63'd0, Out_Valid}, 64'd0);

    // async reset mid-wait: immediate clear, pending write lost
    drive(2'd1, 32'h0, 1'b0, 2'd2, 1'b0, 2'd0, 5'd13, 1'b1);
    tick;
    In_Valid = 1'b0;
    chk("rst_wait_busy", {63'd0, Busy}, 64'd1);
    #2 Rst = 1'b1;
    #1;
    chk("arst_busy", {63'd0, Busy}, 64'd0);
    chk("arst_data", {32'd0, Write_Data_Output}, 64'd0);
    chk("arst_dest", {59'd0, Out_Dest_Reg}, 64'd0);
    chk("arst_rw", {63'd0, Out_Reg_Write}, 64'd0);
    Rst = 1'b0;
    src[1] = 32'h7777_7777; Mem_Data_Valid = 1'b1;
    tick;
    idle_in;
    chk("arst_lost", {63'd0, Out_Valid}, 64'd0);
    tick; tick;

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
